// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with
// a same-cycle redirect, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_mem_write,
  input  logic            ex_mem_flush,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [2:0]      funct3_in,
  input  logic [4:0]      rd_in,
  input  logic [3:0]      alu_ctrl_in,
  input  logic [2:0]      branch_ctrl_in,
  input  logic [1:0]      wb_sel_in,
  input  logic            reg_write_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            alu_src_in,
  input  logic            branch_in,
  input  logic            jal_in,
  input  logic            jalr_in,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] ex_mem_alu_result,
  output logic [XLEN-1:0] ex_mem_store_data,
  output logic [XLEN-1:0] ex_mem_pc_plus4,
  output logic [4:0]      ex_mem_rd,
  output logic [2:0]      ex_mem_funct3,
  output logic [1:0]      ex_mem_wb_sel,
  output logic            ex_mem_reg_write,
  output logic            ex_mem_mem_read,
  output logic            ex_mem_mem_write
);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      shamt;
  logic            br_eq;
  logic            br_lt;
  logic            br_ltu;
  logic            br_taken;
  logic [XLEN-1:0] jalr_sum;

  // Encodings 00 and 11 both select the register file.
  always_comb begin
    case (fwd_a)
      2'b01:   op_a = mem_fwd_data;
      2'b10:   op_a = wb_fwd_data;
      default: op_a = rs1_data_in;
    endcase
    case (fwd_b)
      2'b01:   op_b = mem_fwd_data;
      2'b10:   op_b = wb_fwd_data;
      default: op_b = rs2_data_in;
    endcase
  end

  assign alu_b = alu_src_in ? imm_in : op_b;
  assign shamt = alu_b[4:0];

  always_comb begin
    case (alu_ctrl_in)
      ALU_ADD:  alu_result = op_a + alu_b;
      ALU_SUB:  alu_result = op_a - alu_b;
      ALU_SLL:  alu_result = op_a << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(alu_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, op_a < alu_b};
      ALU_XOR:  alu_result = op_a ^ alu_b;
      ALU_SRL:  alu_result = op_a >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:   alu_result = op_a | alu_b;
      ALU_AND:  alu_result = op_a & alu_b;
      ALU_PASS: alu_result = alu_b;
      default:  alu_result = '0;
    endcase
  end

  // Branches always compare the two forwarded register operands, never the immediate.
  assign br_eq  = (op_a == op_b);
  assign br_lt  = ($signed(op_a) < $signed(op_b));
  assign br_ltu = (op_a < op_b);

  always_comb begin
    case (branch_ctrl_in)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = ~br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = ~br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = ~br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  assign jalr_sum       = op_a + imm_in;
  assign redirect_valid = (branch_in & br_taken) | jal_in | jalr_in;
  assign redirect_pc    = jalr_in ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_in + imm_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_pc_plus4   <= '0;
      ex_mem_rd         <= '0;
      ex_mem_funct3     <= '0;
      ex_mem_wb_sel     <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
    end else if (ex_mem_flush) begin
      ex_mem_alu_result <= '0;
      ex_mem_store_data <= '0;
      ex_mem_pc_plus4   <= '0;
      ex_mem_rd         <= '0;
      ex_mem_funct3     <= '0;
      ex_mem_wb_sel     <= '0;
      ex_mem_reg_write  <= 1'b0;
      ex_mem_mem_read   <= 1'b0;
      ex_mem_mem_write  <= 1'b0;
    end else if (ex_mem_write) begin
      ex_mem_alu_result <= alu_result;
      ex_mem_store_data <= op_b;
      ex_mem_pc_plus4   <= pc_in + 32'd4;
      ex_mem_rd         <= rd_in;
      ex_mem_funct3     <= funct3_in;
      ex_mem_wb_sel     <= wb_sel_in;
      ex_mem_reg_write  <= reg_write_in;
      ex_mem_mem_read   <= mem_read_in;
      ex_mem_mem_write  <= mem_write_in;
    end
  end

endmodule
